limem_op_sched: RTL and testbench
=================================

LIMEM_OP_SCHED -- requirements
Module: limem_op_sched

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the controlled logic-in-memory register.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  in  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  out  1 each  operation from requester N accepted this cycle.
REQ-006 req0_op / req1_op  in  3 each  opcode: 0 SET, 1 HOLD, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR.
REQ-007 req0_data / req1_data  in  WIDTH each  operand.
REQ-008 resp_valid  out  1  result available.
REQ-009 resp_ready  in  1  consumer accepts result.
REQ-010 resp_id  out  1  index of requester that issued the operation.
REQ-011 resp_data  out  WIDTH  register value after the operation.
REQ-012 lim_force, lim_invert, lim_nand, lim_nxor  out  1 each  controls to the logic-in-memory register.
REQ-013 lim_in  out  WIDTH  operand to the logic-in-memory register.
REQ-014 lim_out  in  WIDTH  current stored value of the logic-in-memory register.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one operation is in flight at a time.
REQ-017 IDLE: if any reqN_valid, the block arbitrates, asserts the winner's reqN_ready combinationally for that cycle only, captures op/data/id, and moves to EXEC.
REQ-018 Both valid: the requester not granted last wins (round robin); a single valid requester always wins.
REQ-019 The loser's ready stays 0; its valid/op/data must be held and are served no earlier than the next IDLE.
REQ-020 reqN_ready is 0 in EXEC and RESP.
REQ-021 EXEC lasts exactly one cycle and drives the decoded controls with lim_in = captured data; the register updates on the edge ending EXEC.
REQ-022 Decode (force, invert, nand, nxor): SET 1,0,0,0; AND 0,1,1,0; NAND 0,0,1,0; OR 0,1,0,0; NOR 0,0,0,0; XOR 0,1,0,1; XNOR 0,0,0,1.
REQ-023 HOLD decodes to force=0, invert=1, nand=0, nxor=0 with lim_in forced to 0 regardless of captured data.
REQ-024 In IDLE and RESP the block drives the HOLD controls with lim_in=0 so the register is unchanged.
REQ-025 RESP: resp_valid=1, resp_id=captured id, resp_data=lim_out; resp_valid, resp_id and resp_data stay stable until resp_ready.
REQ-026 RESP with resp_ready=1 returns to IDLE on that edge; a new request can be accepted in the following cycle, never in the same cycle.
REQ-027 Latency, accept to resp_valid: 2 cycles (accept edge, EXEC edge).
REQ-028 The round-robin pointer updates only on accept, to the granted index.

Reset
REQ-029 While rst=1: state=IDLE, pointer set so req0 wins the first tie, captured regs=0.
REQ-030 While rst=1: req*_ready=0, resp_valid=0, resp_id=0, resp_data driven from lim_out (don't-care), busy=0, lim_* = HOLD with lim_in=0.
REQ-031 Reset asserted in EXEC or RESP aborts the operation; no response is produced and the lost request is not replayed.

Verification
REQ-032 Reset, then req0 SET 0xA5 -> req0_ready in cycle 0; EXEC lim_force=1, lim_invert=0, lim_in=0xA5; cycle 2 resp_valid=1, resp_id=0, resp_data=0xA5.
REQ-033 Register 0xA5, req1 AND 0x0F, then XOR 0xFF, then NOR 0x00 -> responses 0x05, 0xFA, 0x05.
REQ-034 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; each grant is followed by exactly one response carrying the matching id.
REQ-035 Register 0x3C, HOLD with data 0xFF -> lim_in=0 during EXEC; resp_data=0x3C.
REQ-036 resp_ready held low 5 cycles in RESP -> resp_valid and resp_data stable; req*_ready stays 0; register unchanged.
REQ-037 rst pulsed during EXEC -> next cycle outputs at reset values, no resp_valid; a following tie grants req0.

Source files
------------

// File: rtl/limem_op_sched.sv
// Operation scheduler for a logic-in-memory register: round-robin arbitration
// between two requesters, one operation in flight, result held until consumed.
module limem_op_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             lim_force,
  output logic             lim_invert,
  output logic             lim_nand,
  output logic             lim_nxor,
  output logic [WIDTH-1:0] lim_in,
  input  logic [WIDTH-1:0] lim_out,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_SET  = 3'd0;
  localparam logic [2:0] OP_HOLD = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             grant0, grant1;

  // last_q holds the index granted most recently; resetting it to 1 lets req0 win the first tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == ST_IDLE) && !rst) begin
      if (req0_valid && (!req1_valid || last_q)) grant0 = 1'b1;
      else if (req1_valid)                       grant1 = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    data_d  = data_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          state_d = ST_EXEC;
          last_d  = 1'b0;
          id_d    = 1'b0;
          op_d    = req0_op;
          data_d  = req0_data;
        end else if (grant1) begin
          state_d = ST_EXEC;
          last_d  = 1'b1;
          id_d    = 1'b1;
          op_d    = req1_op;
          data_d  = req1_data;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      op_q    <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  // Outside EXEC the register sees an OR with zero, which leaves it unchanged.
  always_comb begin
    lim_force  = 1'b0;
    lim_invert = 1'b1;
    lim_nand   = 1'b0;
    lim_nxor   = 1'b0;
    lim_in     = '0;
    if (state_q == ST_EXEC) begin
      lim_in = data_q;
      case (op_q)
        OP_SET:  begin lim_force = 1'b1; lim_invert = 1'b0; end
        OP_HOLD: lim_in = '0;
        OP_AND:  lim_nand = 1'b1;
        OP_NAND: begin lim_invert = 1'b0; lim_nand = 1'b1; end
        OP_OR:   lim_invert = 1'b1;
        OP_NOR:  lim_invert = 1'b0;
        OP_XOR:  lim_nxor = 1'b1;
        OP_XNOR: begin lim_invert = 1'b0; lim_nxor = 1'b1; end
        default: lim_in = '0;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = resp_valid & id_q;
  assign resp_data  = lim_out;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_limem_op_sched.sv
// Bench for limem_op_sched: behavioural logic-in-memory register plus an
// opcode-level reference model for results, grants and control decode.
module tb_limem_op_sched;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_data, req1_data;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_data;
  logic         lim_force, lim_invert, lim_nand, lim_nxor;
  logic [W-1:0] lim_in, lim_out;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] ref_reg = '0;
  logic [W-1:0] lim_reg = '0;
  logic [W-1:0] lim_t;

  limem_op_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .lim_force(lim_force), .lim_invert(lim_invert), .lim_nand(lim_nand), .lim_nxor(lim_nxor),
    .lim_in(lim_in), .lim_out(lim_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // The external logic-in-memory register driven by the controls.
  always_comb begin
    if (lim_nand)      lim_t = ~(lim_reg & lim_in);
    else if (lim_nxor) lim_t = ~(lim_reg ^ lim_in);
    else               lim_t = ~(lim_reg | lim_in);
  end
  always @(posedge clk) begin
    if (lim_force) lim_reg <= lim_in;
    else           lim_reg <= lim_invert ? ~lim_t : lim_t;
  end
  assign lim_out = lim_reg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] apply_op(input logic [2:0] op, input logic [W-1:0] r,
                                            input logic [W-1:0] d);
    case (op)
      3'd0: return d;
      3'd1: return r;
      3'd2: return r & d;
      3'd3: return ~(r & d);
      3'd4: return r | d;
      3'd5: return ~(r | d);
      3'd6: return r ^ d;
      default: return ~(r ^ d);
    endcase
  endfunction

  // {force, invert, nand, nxor}
  function automatic logic [3:0] dec_exp(input logic [2:0] op);
    case (op)
      3'd0: return 4'b1000;
      3'd1: return 4'b0100;
      3'd2: return 4'b0110;
      3'd3: return 4'b0010;
      3'd4: return 4'b0100;
      3'd5: return 4'b0000;
      3'd6: return 4'b0101;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic set_req(input bit id, input logic v, input logic [2:0] op, input logic [W-1:0] d);
    if (id) begin req1_valid = v; req1_op = op; req1_data = d; end
    else    begin req0_valid = v; req0_op = op; req0_data = d; end
  endtask

  task automatic chk_hold_ctl(input string tag);
    chk(tag, {lim_force, lim_invert, lim_nand, lim_nxor, lim_in}, {4'b0100, 8'h00});
  endtask

  task automatic run_op(input bit id, input logic [2:0] op, input logic [W-1:0] d,
                        input int unsigned stall);
    logic [W-1:0] exp_res;
    @(negedge clk);
    set_req(id, 1'b1, op, d);
    #1;
    chk("ready_win",  id ? req1_ready : req0_ready, 1);
    chk("ready_lose", id ? req0_ready : req1_ready, 0);
    chk("busy_idle",  busy, 0);
    @(negedge clk);
    set_req(id, 1'b0, 3'd0, '0);
    #1;
    exp_res = apply_op(op, ref_reg, d);
    chk("exec_busy",  busy, 1);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    chk("exec_rv",    resp_valid, 0);
    chk("exec_ctl",   {lim_force, lim_invert, lim_nand, lim_nxor}, dec_exp(op));
    chk("exec_in",    lim_in, (op == 3'd1) ? '0 : d);
    @(negedge clk);
    #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id",    resp_id, id);
    chk("resp_data",  resp_data, exp_res);
    chk_hold_ctl("resp_ctl");
    set_req(!id, 1'b1, 3'd0, 8'h5A);
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      chk("stall_rv",    resp_valid, 1);
      chk("stall_id",    resp_id, id);
      chk("stall_data",  resp_data, exp_res);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
    end
    resp_ready = 1'b1;
    set_req(!id, 1'b0, 3'd0, '0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("done_rv",   resp_valid, 0);
    chk("done_busy", busy, 0);
    ref_reg = exp_res;
  endtask

  initial begin
    logic [2:0]   op0, op1, wop;
    logic [W-1:0] d0, d1, wd, exp_res;
    bit           w;
    int unsigned  stall;

    rst = 1'b1;
    resp_ready = 1'b0;
    set_req(0, 1'b1, 3'd0, 8'h11);
    set_req(1, 1'b1, 3'd0, 8'h22);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_rv",    resp_valid, 0);
      chk("rst_id",    resp_id, 0);
      chk("rst_busy",  busy, 0);
      chk_hold_ctl("rst_ctl");
    end
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 3'd0, '0);
    set_req(1, 1'b0, 3'd0, '0);

    run_op(0, 3'd0, 8'hA5, 0);
    run_op(1, 3'd2, 8'h0F, 0);
    run_op(1, 3'd6, 8'hFF, 1);
    run_op(1, 3'd5, 8'h00, 0);
    run_op(0, 3'd0, 8'h3C, 0);
    run_op(1, 3'd1, 8'hFF, 5);

    for (int k = 0; k < 12; k++)
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2));

    // Abort: req0 accepted (pointer now favours req1), reset during EXEC.
    @(negedge clk);
    set_req(0, 1'b1, 3'd0, 8'($urandom));
    #1;
    chk("abort_accept", req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, '0);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rv",   resp_valid, 0);
    chk_hold_ctl("abort_ctl");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      #1;
      chk("post_rv",   resp_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_reg",  lim_out, ref_reg);
      @(negedge clk);
    end

    // Both requesters continuously valid: grants must alternate from req0.
    op0 = 3'($urandom_range(0, 7)); d0 = 8'($urandom);
    op1 = 3'($urandom_range(0, 7)); d1 = 8'($urandom);
    set_req(0, 1'b1, op0, d0);
    set_req(1, 1'b1, op1, d1);
    w = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr_grant", {req0_ready, req1_ready}, w ? 2'b01 : 2'b10);
      wop = w ? op1 : op0;
      wd  = w ? d1 : d0;
      exp_res = apply_op(wop, ref_reg, wd);
      @(negedge clk);
      if (w) begin op1 = 3'($urandom_range(0, 7)); d1 = 8'($urandom); set_req(1, 1'b1, op1, d1); end
      else   begin op0 = 3'($urandom_range(0, 7)); d0 = 8'($urandom); set_req(0, 1'b1, op0, d0); end
      #1;
      chk("rr_exec_ready", {req0_ready, req1_ready}, 0);
      chk("rr_exec_ctl",   {lim_force, lim_invert, lim_nand, lim_nxor}, dec_exp(wop));
      @(negedge clk);
      stall = $urandom_range(0, 2);
      #1;
      chk("rr_resp_rv",   resp_valid, 1);
      chk("rr_resp_id",   resp_id, w);
      chk("rr_resp_data", resp_data, exp_res);
      for (int unsigned i = 0; i < stall; i++) begin
        @(negedge clk);
        #1;
        chk("rr_stall_data", resp_data, exp_res);
      end
      resp_ready = 1'b1;
      #1;
      chk("rr_resp_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      resp_ready = 1'b0;
      ref_reg = exp_res;
      w = !w;
    end
    set_req(0, 1'b0, 3'd0, '0);
    set_req(1, 1'b0, 3'd0, '0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
